clk_div_multi: RTL and testbench

//  NCH-channel programmable clock divider. Successor to the fixed single-channel divider.

---
 rtl/clk_div_pkg.sv | 27 ++
 rtl/clk_div_chan.sv | 123 ++++++++++++
 rtl/clk_div_multi.sv | 72 +++++++
 tb/tb_clk_div_multi.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_pkg
// Purpose : Shared constants, types and the terminal-count helper used by the
//           multi-channel clock divider.
// Ports   : none (package)
// Config  : used identically with or without CLK_DIV_SYNC_EN
// Revision: 1.0 - initial release
// ============================================================================
package clk_div_pkg;

  localparam int CLKDIV_WIDTH_DEF = 32;
  localparam int CLKDIV_NCH_MAX   = 16;
  // Compare width for the helper; any channel WIDTH up to this is supported.
  localparam int CLKDIV_CMP_W     = 64;

  typedef logic [CLKDIV_WIDTH_DEF-1:0] div_t;
  typedef logic [CLKDIV_CMP_W-1:0]     cmp_t;

  // Terminal cycle of a half-period. A zero divisor never terminates, so a
  // stopped channel can never toggle through this path.
  function automatic logic is_terminal(input cmp_t cnt, input cmp_t div);
    return (div != '0) && (cnt == div - cmp_t'(1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_chan
// Purpose : One divider channel: half-period counter, current and pending
//           divisor, 50%-duty output clock and toggle tick.
// Ports   : CLK_in      system clock
//           rst_n       synchronous active-low reset
//           en_i        channel run enable
//           sync_i      phase-align request (tied low when unused)
//           wr_i        divisor write addressed to this channel
//           wr_div_i    new divisor (0 = stop)
//           clk_o       divided clock
//           tick_o      one-cycle pulse after each toggle
//           pend_o      written divisor not yet applied
// Config  : independent of CLK_DIV_SYNC_EN (sync_i is fed by the top)
// Revision: 1.0 - initial release
// ============================================================================
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int               WIDTH   = CLKDIV_WIDTH_DEF,
  parameter logic [WIDTH-1:0] DEF_DIV = WIDTH'(50_000_000)
) (
  input  logic             CLK_in,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_div_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             pend_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_cur_q, div_cur_d;
  logic [WIDTH-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] w_div_nxt;
  logic             w_term;

  assign w_term = is_terminal(cmp_t'(cnt_q), cmp_t'(div_cur_q));

  always_comb begin
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;
    w_div_nxt  = div_cur_q;

    if (sync_i) begin
      // Phase alignment: restart low, taking any queued divisor now.
      cnt_d = '0;
      clk_d = 1'b0;
      if (pend_q) begin
        div_cur_d = div_pend_q;
        pend_d    = 1'b0;
      end
    end else if (!en_i || (div_cur_q == '0)) begin
      // Idle: no half-period in flight, so a write can land immediately.
      // A disabled channel keeps its level; an enabled stopped one sits low.
      cnt_d = '0;
      if (en_i) begin
        clk_d = 1'b0;
      end
      if (wr_i) begin
        div_cur_d = wr_div_i;
        pend_d    = 1'b0;
      end
    end else if (w_term) begin
      // Divisor changes only here, at a half-period boundary. A write in
      // this very cycle overrides any queued value.
      cnt_d = '0;
      if (wr_i) begin
        w_div_nxt = wr_div_i;
      end else if (pend_q) begin
        w_div_nxt = div_pend_q;
      end
      div_cur_d = w_div_nxt;
      pend_d    = 1'b0;
      if (w_div_nxt == '0) begin
        clk_d = 1'b0;
      end else begin
        clk_d  = ~clk_q;
        tick_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
      if (wr_i) begin
        div_pend_d = wr_div_i;
        pend_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_in) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      div_cur_q  <= DEF_DIV;
      div_pend_q <= '0;
      pend_q     <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign pend_o = pend_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_multi
// Purpose : NCH-channel run-time programmable clock divider with glitch-free
//           divisor changes at half-period boundaries.
// Ports   : CLK_in      system clock
//           rst_n       synchronous active-low reset
//           en          per-channel run enable
//           wr_en       divisor write strobe
//           wr_ch       write target channel (>= NCH ignored)
//           wr_div      new divisor (0 = stop channel)
//           sync_start  phase-align all channels (only with CLK_DIV_SYNC_EN)
//           CLK_out     divided clocks
//           tick        one-cycle pulse per CLK_out toggle
//           pend        divisor written but not yet applied
// Config  : `define CLK_DIV_SYNC_EN adds the sync_start input.
// Revision: 1.0 - initial release
// ============================================================================
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int               NCH     = 4,
  parameter int               WIDTH   = CLKDIV_WIDTH_DEF,
  parameter logic [WIDTH-1:0] DEF_DIV = WIDTH'(50_000_000)
) (
  input  logic                 CLK_in,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       en,
  input  logic                 wr_en,
  input  logic [$clog2(NCH):0] wr_ch,
  input  logic [WIDTH-1:0]     wr_div,
`ifdef CLK_DIV_SYNC_EN
  input  logic                 sync_start,
`endif
  output logic [NCH-1:0]       CLK_out,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       pend
);

  localparam int CHW = $clog2(NCH) + 1;

  logic w_sync;

`ifdef CLK_DIV_SYNC_EN
  assign w_sync = sync_start;
`else
  assign w_sync = 1'b0;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic w_wr;
    // Out-of-range channel numbers match no instance, so they are dropped.
    assign w_wr = wr_en && (wr_ch == CHW'(i));

    clk_div_chan #(
      .WIDTH   (WIDTH),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .CLK_in   (CLK_in),
      .rst_n    (rst_n),
      .en_i     (en[i]),
      .sync_i   (w_sync),
      .wr_i     (w_wr),
      .wr_div_i (wr_div),
      .clk_o    (CLK_out[i]),
      .tick_o   (tick[i]),
      .pend_o   (pend[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_clk_div_multi
// Purpose : Self-checking bench for clk_div_multi: directed scenarios followed
//           by randomized traffic, all compared against a behavioural model
//           that tracks cycles remaining in each half-period.
// Config  : exercises sync_start when CLK_DIV_SYNC_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_clk_div_multi;

  localparam int NCH   = 4;
  localparam int WIDTH = 8;
  localparam int CHW   = $clog2(NCH) + 1;
  localparam logic [WIDTH-1:0] DEF = 8'd4;

  logic             CLK_in = 1'b0;
  logic             rst_n  = 1'b0;
  logic [NCH-1:0]   en     = '0;
  logic             wr_en  = 1'b0;
  logic [CHW-1:0]   wr_ch  = '0;
  logic [WIDTH-1:0] wr_div = '0;
`ifdef CLK_DIV_SYNC_EN
  logic             sync_start = 1'b0;
`endif
  logic [NCH-1:0]   CLK_out, tick, pend;

  clk_div_multi #(.NCH(NCH), .WIDTH(WIDTH), .DEF_DIV(DEF)) dut (
    .CLK_in     (CLK_in),
    .rst_n      (rst_n),
    .en         (en),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_div     (wr_div),
`ifdef CLK_DIV_SYNC_EN
    .sync_start (sync_start),
`endif
    .CLK_out    (CLK_out),
    .tick       (tick),
    .pend       (pend)
  );

  always #5 CLK_in = ~CLK_in;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: divisor, cycles left in the current half-period, queued divisor.
  int m_div [NCH];
  int m_left[NCH];
  int m_pdiv[NCH];
  bit m_pend[NCH];
  bit m_clk [NCH];
  bit m_tick[NCH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mvec(input int sel);
    logic [31:0] v = '0;
    for (int i = 0; i < NCH; i++)
      v[i] = (sel == 0) ? m_clk[i] : (sel == 1) ? m_tick[i] : m_pend[i];
    return v;
  endfunction

  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      bit wr;
      int nd;
      wr = wr_en && (int'(wr_ch) == i);
      if (!rst_n) begin
        m_div[i] = int'(DEF); m_left[i] = int'(DEF); m_pdiv[i] = 0;
        m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
      end
`ifdef CLK_DIV_SYNC_EN
      else if (sync_start) begin
        if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 0; end
        m_left[i] = m_div[i]; m_clk[i] = 0; m_tick[i] = 0;
      end
`endif
      else begin
        m_tick[i] = 0;
        if (!en[i] || m_div[i] == 0) begin
          if (en[i]) m_clk[i] = 0;
          if (wr) begin m_div[i] = int'(wr_div); m_pend[i] = 0; end
          m_left[i] = m_div[i];
        end else if (m_left[i] == 1) begin
          nd = wr ? int'(wr_div) : (m_pend[i] ? m_pdiv[i] : m_div[i]);
          m_pend[i] = 0; m_div[i] = nd; m_left[i] = nd;
          if (nd == 0) m_clk[i] = 0;
          else begin m_clk[i] = !m_clk[i]; m_tick[i] = 1; end
        end else begin
          m_left[i]--;
          if (wr) begin m_pdiv[i] = int'(wr_div); m_pend[i] = 1; end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge CLK_in);
    model_step();
    @(negedge CLK_in);
    check("clk_out", 32'(CLK_out), mvec(0));
    check("tick",    32'(tick),    mvec(1));
    check("pend",    32'(pend),    mvec(2));
  endtask

  task automatic do_write(input int ch, input int d);
    wr_en = 1'b1; wr_ch = CHW'(ch); wr_div = WIDTH'(d);
    step();
    wr_en = 1'b0;
  endtask

  // Advance until the model channel has 'left' cycles remaining (bounded).
  task automatic wait_left(input int ch, input int left);
    int n = 0;
    while (m_left[ch] != left && n < 64) begin step(); n++; end
    check("wait_left_bound", 32'(m_left[ch] == left), 32'd1);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    step();
    check("rst_clk",  32'(CLK_out), 32'd0);
    check("rst_pend", 32'(pend),    32'd0);

    // Default divisor 4: rise after 4 edges, fall after 8, tick with each
    rst_n = 1'b1; en = '1;
    repeat (3) step();
    check("t1_pre", 32'(CLK_out[0]), 32'd0);
    step();
    check("t1_rise", 32'(CLK_out[0]), 32'd1);
    check("t1_tick", 32'(tick[0]),    32'd1);
    repeat (4) step();
    check("t1_fall", 32'(CLK_out[0]), 32'd0);
    check("t1_tick2", 32'(tick[0]),   32'd1);

    // Channel 0 to div 3, then write 5 mid half-period
    do_write(0, 3);
    wait_left(0, 3);
    step();
    do_write(0, 5);
    check("t2_pend", 32'(pend[0]), 32'd1);
    repeat (20) step();

    // Stop channel 2, then restart with div 2
    do_write(2, 0);
    repeat (10) step();
    check("t3_stopped", 32'(CLK_out[2]), 32'd0);
    do_write(2, 2);
    step();
    check("t3_wait", 32'(CLK_out[2]), 32'd0);
    step();
    check("t3_rise", 32'(CLK_out[2]), 32'd1);

    // Write landing in the terminal cycle; then an out-of-range channel write
    wait_left(3, 1);
    do_write(3, 7);
    check("t4_nopend", 32'(pend[3]), 32'd0);
    repeat (16) step();
    do_write(NCH, 1);
    check("t4_badch", 32'(pend), 32'd0);
    repeat (4) step();

    // Disable channel 1 while high, then re-enable
    begin
      int n = 0;
      while (!m_clk[1] && n < 64) begin step(); n++; end
      check("t5_high_bound", 32'(m_clk[1]), 32'd1);
    end
    en[1] = 1'b0;
    repeat (8) step();
    check("t5_hold", 32'(CLK_out[1]), 32'd1);
    check("t5_notick", 32'(tick[1]), 32'd0);
    en[1] = 1'b1;
    repeat (12) step();

`ifdef CLK_DIV_SYNC_EN
    do_write(0, 3);
    do_write(1, 5);
    repeat (12) step();
    sync_start = 1'b1;
    step();
    sync_start = 1'b0;
    check("t6_sync_low", 32'(CLK_out[1:0]), 32'd0);
    repeat (12) step();
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n  = ($urandom_range(499) != 0);
      if ($urandom_range(15) == 0) en[$urandom_range(NCH-1)] ^= 1'b1;
      wr_en  = ($urandom_range(3) == 0);
      wr_ch  = CHW'($urandom_range(7));
      wr_div = WIDTH'(($urandom_range(9) == 0) ? 0 : $urandom_range(1, 6));
`ifdef CLK_DIV_SYNC_EN
      sync_start = ($urandom_range(99) == 0);
`endif
      step();
    end
    wr_en = 1'b0;
`ifdef CLK_DIV_SYNC_EN
    sync_start = 1'b0;
`endif

    // Reset mid-run clears every output on the next edge
    rst_n = 1'b1; en = '1;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    check("rst_mid_clk",  32'(CLK_out), 32'd0);
    check("rst_mid_tick", 32'(tick),    32'd0);
    check("rst_mid_pend", 32'(pend),    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
